pipeline_ctrl: RTL

//  Consumer side of the hazard unit: turns hazard/branch/jump, ihit/dhit and WB halt into per-latch

---
 rtl/pipeline_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: turns hazard/redirect/cache-hit/halt status into pipeline latch enables,
// bubble/flush controls and PC-update controls, with saturating stall/flush counters.
module pipeline_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hazard,
  input  logic              i_branch,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_redir_target,
  input  logic              i_ihit,
  input  logic              i_dhit,
  input  logic              i_mem_dren,
  input  logic              i_mem_dwen,
  input  logic              i_halt_wb,
  output logic              o_pc_en,
  output logic              o_pc_sel,
  output logic [ADDR_W-1:0] o_pc_target,
  output logic              o_if_id_en,
  output logic              o_id_ex_en,
  output logic              o_ex_mem_en,
  output logic              o_mem_wb_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_flush,
  output logic              o_halt,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);
  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;
  state_t            r_st;
  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_tgt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_halted, w_dstall, w_live;
  logic              w_hw, w_ds, w_hz, w_pd, w_br, w_nm;
  assign w_halted = r_st == HALTED;
  assign w_dstall = (i_mem_dren | i_mem_dwen) & ~i_dhit;
  assign w_live   = ~w_halted & ~i_halt_wb & ~w_dstall & ~i_hazard;
  // One-hot selection of the active priority rule for this cycle
  assign w_hw = ~w_halted & i_halt_wb;
  assign w_ds = ~w_halted & ~i_halt_wb & w_dstall;
  assign w_hz = ~w_halted & ~i_halt_wb & ~w_dstall & i_hazard;
  assign w_pd = w_live & r_pend;
  assign w_br = w_live & ~r_pend & (i_branch | i_jump);
  assign w_nm = w_live & ~r_pend & ~(i_branch | i_jump);
  assign o_halt      = w_halted;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
  always_comb begin
    o_pc_en       = 1'b0;
    o_pc_sel      = 1'b0;
    o_pc_target   = '0;
    o_if_id_en    = 1'b0;
    o_id_ex_en    = 1'b0;
    o_ex_mem_en   = 1'b0;
    o_mem_wb_en   = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    if (!i_rst) begin
      o_mem_wb_en   = w_hw | w_hz | w_pd | w_br | w_nm;
      o_ex_mem_en   = w_hz | w_pd | w_br | w_nm;
      o_id_ex_en    = w_hz | w_pd | w_br | w_nm;
      o_id_ex_flush = w_hz;
      o_if_id_en    = w_pd | w_br | w_nm;
      o_if_id_flush = w_pd | w_br | (w_nm & ~i_ihit);
      o_pc_en       = (w_pd | w_br | w_nm) & i_ihit;
      o_pc_sel      = w_pd | (w_br & i_ihit);
      o_pc_target   = w_pd ? r_pend_tgt : w_br ? i_redir_target : '0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st        <= RUN;
      r_pend      <= 1'b0;
      r_pend_tgt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_st <= (w_halted | w_hw) ? HALTED : w_ds ? DWAIT : RUN;
      if (w_pd & i_ihit) r_pend <= 1'b0;
      else if (w_br & ~i_ihit) begin
        r_pend     <= 1'b1;
        r_pend_tgt <= i_redir_target;
      end
      if ((w_ds | w_hz) & ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if ((w_pd | w_br) & i_ihit & ~&r_flush_cnt) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end
endmodule
